// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - shared opcodes, T-state encodings and control word layout for the SAP-1 sequencer
package sap_pkg;

    // Instruction opcodes (upper nibble of the instruction register)
    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_JMP = 4'h3;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // One-hot ring counter states, bit0 = T1
    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    // Control word, MSB first in this field order
    typedef struct packed {
        logic cp;
        logic ep;
        logic lm;
        logic mar_en;
        logic ce;
        logic li;
        logic ei;
        logic la;
        logic ea;
        logic su;
        logic eu;
        logic lb;
        logic lo;
        logic lp;
    } ctrl_word_t;

endpackage

// File: rtl/sap_ring_counter.sv
// rtl/sap_ring_counter.sv - six-state one-hot T-state ring counter
//
// Ports:
//   clk     in   ring advances on the falling edge
//   clr     in   asynchronous active-high reset to T1
//   freeze  in   hold the current state (used while halted)
//   t_state out  one-hot state, bit0 = T1
module sap_ring_counter
    import sap_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       freeze,
    output logic [5:0] t_state
);

    logic [5:0] t_state_q;
    logic [5:0] t_state_d;

    always_comb begin
        t_state_d = t_state_q;
        // Any non-one-hot pattern is recovered to T1, even while frozen.
        if (!$onehot(t_state_q)) begin
            t_state_d = T1;
        end else if (!freeze) begin
            t_state_d = {t_state_q[4:0], t_state_q[5]};
        end
    end

    always_ff @(negedge clk or posedge clr) begin
        if (clr) begin
            t_state_q <= T1;
        end else begin
            t_state_q <= t_state_d;
        end
    end

    assign t_state = t_state_q;

endmodule

// File: rtl/sap_controller_sequencer.sv
// rtl/sap_controller_sequencer.sv - SAP-1 controller-sequencer: ring counter plus opcode decode
//
// Optional feature macro: SAP_JUMP_EN (JMP opcode asserts ei/lp at T4).
//
// Parameters:
//   OP_W           opcode width
//   HALT_ON_UNDEF  1 = undefined opcode halts like HLT, 0 = executes as NOP
// Ports:
//   clk      in   system clock; state advances on the falling edge
//   clr      in   asynchronous active-high reset; forces all strobes low
//   opcode   in   instruction register bits [7:4]
//   t_state  out  one-hot ring counter, bit0 = T1
//   cp ep lm mar_en ce li ei la ea su eu lb lo lp  out  datapath strobes
//   halt     out  processor halted
module sap_controller_sequencer
    import sap_pkg::*;
#(
    parameter int OP_W          = 4,
    parameter int HALT_ON_UNDEF = 0
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [OP_W-1:0] opcode,
    output logic [5:0]      t_state,
    output logic            cp,
    output logic            ep,
    output logic            lm,
    output logic            mar_en,
    output logic            ce,
    output logic            li,
    output logic            ei,
    output logic            la,
    output logic            ea,
    output logic            su,
    output logic            eu,
    output logic            lb,
    output logic            lo,
    output logic            lp,
    output logic            halt
);

    logic [OP_W-1:0] op_q;
    logic [OP_W-1:0] op_d;
    logic            halt_q;
    logic            halt_d;
    ctrl_word_t      cw;

    logic is_lda;
    logic is_add;
    logic is_sub;
    logic is_jmp;
    logic is_out;
    logic is_hlt;
    logic op_defined;
    logic halts_here;

    sap_ring_counter u_ring (
        .clk     (clk),
        .clr     (clr),
        .freeze  (halt_q),
        .t_state (t_state)
    );

    assign is_lda = (op_q == OP_W'(OP_LDA));
    assign is_add = (op_q == OP_W'(OP_ADD));
    assign is_sub = (op_q == OP_W'(OP_SUB));
    assign is_out = (op_q == OP_W'(OP_OUT));
    assign is_hlt = (op_q == OP_W'(OP_HLT));
`ifdef SAP_JUMP_EN
    assign is_jmp = (op_q == OP_W'(OP_JMP));
`else
    assign is_jmp = 1'b0;
`endif

    assign op_defined = is_lda | is_add | is_sub | is_out | is_hlt | is_jmp;
    assign halts_here = is_hlt | ((HALT_ON_UNDEF != 0) & ~op_defined);

    // Opcode is captured as T3 ends (after li); halt latches as T4 ends.
    always_comb begin
        op_d   = op_q;
        halt_d = halt_q;
        if (!halt_q && (t_state == T3)) begin
            op_d = opcode;
        end
        if (!halt_q && (t_state == T4) && halts_here) begin
            halt_d = 1'b1;
        end
    end

    always_ff @(negedge clk or posedge clr) begin
        if (clr) begin
            op_q   <= '0;
            halt_q <= 1'b0;
        end else begin
            op_q   <= op_d;
            halt_q <= halt_d;
        end
    end

    always_comb begin
        cw = '0;
        if (!clr && !halt_q) begin
            case (t_state)
                T1: begin
                    cw.ep = 1'b1;
                    cw.lm = 1'b1;
                end
                T2: cw.cp = 1'b1;
                T3: begin
                    cw.ce = 1'b1;
                    cw.li = 1'b1;
                end
                T4: begin
                    if (is_lda || is_add || is_sub) begin
                        cw.ei = 1'b1;
                        cw.lm = 1'b1;
                    end else if (is_out) begin
                        cw.ea = 1'b1;
                        cw.lo = 1'b1;
                    end else if (is_jmp) begin
                        cw.ei = 1'b1;
                        cw.lp = 1'b1;
                    end
                end
                T5: begin
                    if (is_lda) begin
                        cw.ce = 1'b1;
                        cw.la = 1'b1;
                    end else if (is_add || is_sub) begin
                        cw.ce = 1'b1;
                        cw.lb = 1'b1;
                    end
                end
                T6: begin
                    if (is_add || is_sub) begin
                        cw.eu = 1'b1;
                        cw.la = 1'b1;
                        cw.su = is_sub;
                    end
                end
                default: ;
            endcase
        end
        // The address register gates both load and output with its enable.
        cw.mar_en = cw.lm | cw.ce;
    end

    assign cp     = cw.cp;
    assign ep     = cw.ep;
    assign lm     = cw.lm;
    assign mar_en = cw.mar_en;
    assign ce     = cw.ce;
    assign li     = cw.li;
    assign ei     = cw.ei;
    assign la     = cw.la;
    assign ea     = cw.ea;
    assign su     = cw.su;
    assign eu     = cw.eu;
    assign lb     = cw.lb;
    assign lo     = cw.lo;
    assign lp     = cw.lp;
    assign halt   = halt_q;

endmodule
